seq_serializer: RTL and testbench

- Transmit-side counterpart of the serial sequence detector: accepts a parallel word through a valid/ready handshake and drives it out one bit per clock on a serial line.
- With default parameters it produces the 12-bit pattern 1110_1101_1011 in the bit order the detector expects (bit 0 first).
- Sits upstream of the detector in loopback and self-check setups; supports inter-frame gaps and automatic repeat.

---
 rtl/seq_serializer.sv | 115 +++++++++++
 tb/tb_seq_serializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial transmitter: captures a word through a valid/ready handshake
// and shifts it out one bit per clock, with optional inter-frame gap and auto-repeat.
module seq_serializer #(
  parameter int   WIDTH      = 12,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             repeat_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0] LAST_GAP = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [7:0]       gap_reg, gap_next;
  logic             rep_reg, rep_next;
  logic [CW-1:0]    bit_idx;
  logic             x_next, x_valid_next, busy_next, done_next, ready_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      cnt_reg      <= '0;
      gap_reg      <= '0;
      rep_reg      <= 1'b0;
      x_o          <= IDLE_BIT;
      x_valid_o    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      load_ready_o <= 1'b1;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      cnt_reg      <= cnt_next;
      gap_reg      <= gap_next;
      rep_reg      <= rep_next;
      x_o          <= x_next;
      x_valid_o    <= x_valid_next;
      busy_o       <= busy_next;
      done_o       <= done_next;
      load_ready_o <= ready_next;
    end
  end

  // The end-of-frame decision is taken while the last bit is on the line.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    rep_next   = rep_reg;
    case (state_reg)
      IDLE: begin
        if (load_valid_i && load_ready_o) begin
          hold_next  = data_i;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == LAST_BIT) begin
          cnt_next = '0;
          rep_next = repeat_i;
          if (HAS_GAP) begin
            gap_next   = '0;
            state_next = GAP;
          end else if (repeat_i) begin
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_reg == LAST_GAP) begin
          gap_next   = '0;
          state_next = rep_reg ? SHIFT : IDLE;
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without extra latency.
  always_comb begin
    bit_idx      = LSB_FIRST ? cnt_next : (LAST_BIT - cnt_next);
    x_valid_next = (state_next == SHIFT);
    x_next       = x_valid_next ? hold_next[bit_idx] : IDLE_BIT;
    done_next    = x_valid_next && (cnt_next == LAST_BIT);
    busy_next    = (state_next != IDLE);
    ready_next   = (state_next == IDLE);
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: default, MSB-first and gap/repeat configurations,
// including ignored loads, repeat sampling and asynchronous mid-frame reset.
module tb_seq_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [11:0] d_data;
  logic        d_lv, d_rep, d_ready, d_x, d_xv, d_busy, d_done;
  logic [7:0]  m_data;
  logic        m_lv, m_rep, m_ready, m_x, m_xv, m_busy, m_done;
  logic [11:0] g_data;
  logic        g_lv, g_rep, g_ready, g_x, g_xv, g_busy, g_done;

  seq_serializer u_def (
    .clk(clk), .reset(reset), .data_i(d_data), .load_valid_i(d_lv), .load_ready_o(d_ready),
    .repeat_i(d_rep), .x_o(d_x), .x_valid_o(d_xv), .busy_o(d_busy), .done_o(d_done)
  );

  seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_i(m_data), .load_valid_i(m_lv), .load_ready_o(m_ready),
    .repeat_i(m_rep), .x_o(m_x), .x_valid_o(m_xv), .busy_o(m_busy), .done_o(m_done)
  );

  seq_serializer #(.GAP_CYCLES(3), .IDLE_BIT(1'b1)) u_gap (
    .clk(clk), .reset(reset), .data_i(g_data), .load_valid_i(g_lv), .load_ready_o(g_ready),
    .repeat_i(g_rep), .x_o(g_x), .x_valid_o(g_xv), .busy_o(g_busy), .done_o(g_done)
  );

  // Expected output bundle: {x, x_valid, done, load_ready, busy}
  typedef struct {
    logic        lv;
    logic [11:0] data;
    logic        rep;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl [27];
  bit   seq_a [12];
  bit   seq_f [12];
  bit   seq_m [8];
  bit   seq_g [12];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] pk(logic x, logic v, logic d, logic r, logic b);
    return {x, v, d, r, b};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {x,v,done,rdy,busy}=%b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  initial begin
    // 12'hEDB LSB-first, then 12'h0FF LSB-first, 8'hA5 MSB-first, 12'hDB7 LSB-first
    seq_a = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    seq_f = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    seq_m = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    seq_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    tbl[0] = '{lv: 1'b1, data: 12'hEDB, rep: 1'b0, exp: pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    for (int k = 0; k < 12; k++)
      tbl[1+k] = '{lv: (k >= 1 && k <= 4), data: 12'h0FF, rep: 1'b0,
                   exp: pk(seq_a[k], 1'b1, k == 11, 1'b0, 1'b1)};
    tbl[13] = '{lv: 1'b1, data: 12'h0FF, rep: 1'b0, exp: pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
    for (int k = 0; k < 12; k++)
      tbl[14+k] = '{lv: 1'b0, data: 12'h000, rep: 1'b0,
                    exp: pk(seq_f[k], 1'b1, k == 11, 1'b0, 1'b1)};
    tbl[26] = '{lv: 1'b0, data: 12'h000, rep: 1'b0, exp: pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};

    reset = 1'b0;
    d_lv = 1'b0; d_data = '0; d_rep = 1'b0;
    m_lv = 1'b0; m_data = '0; m_rep = 1'b0;
    g_lv = 1'b0; g_data = '0; g_rep = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_def", {d_x, d_xv, d_done, d_ready, d_busy}, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("reset_msb", {m_x, m_xv, m_done, m_ready, m_busy}, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    chk("reset_gap", {g_x, g_xv, g_done, g_ready, g_busy}, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    reset = 1'b1;

    // Single frames, loads ignored mid-frame, then accepted in IDLE
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk($sformatf("tbl[%0d]", i), {d_x, d_xv, d_done, d_ready, d_busy}, tbl[i].exp);
      d_lv = tbl[i].lv; d_data = tbl[i].data; d_rep = tbl[i].rep;
    end

    // Back-to-back repeat with no gap; repeat dropped during the third frame
    d_lv = 1'b1; d_data = 12'hEDB; d_rep = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      chk($sformatf("rep[%0d]", k), {d_x, d_xv, d_done, d_ready, d_busy},
          pk(seq_a[k % 12], 1'b1, (k % 12) == 11, 1'b0, 1'b1));
      if (k == 0) begin d_lv = 1'b0; d_data = 12'h000; end
      if (k == 24) d_rep = 1'b0;
    end
    @(negedge clk);
    chk("rep_end", {d_x, d_xv, d_done, d_ready, d_busy}, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // MSB-first, data_i disturbed after the handshake
    m_lv = 1'b1; m_data = 8'hA5;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("msb[%0d]", t), {m_x, m_xv, m_done, m_ready, m_busy},
          pk(seq_m[t], 1'b1, t == 7, 1'b0, 1'b1));
      if (t == 0) begin m_lv = 1'b0; m_data = 8'h00; end
    end
    @(negedge clk);
    chk("msb_end", {m_x, m_xv, m_done, m_ready, m_busy}, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Gap of 3 with repeat; repeat toggled mid-frame (ignored), then dropped in frame 2
    g_lv = 1'b1; g_data = 12'hDB7; g_rep = 1'b1;
    for (int t = 0; t < 31; t++) begin
      logic [4:0] e;
      @(negedge clk);
      if (t < 12)      e = pk(seq_g[t], 1'b1, t == 11, 1'b0, 1'b1);
      else if (t < 15) e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (t < 27) e = pk(seq_g[t-15], 1'b1, t == 26, 1'b0, 1'b1);
      else if (t < 30) e = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      else             e = pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("gap[%0d]", t), {g_x, g_xv, g_done, g_ready, g_busy}, e);
      if (t == 0) begin g_lv = 1'b0; g_data = 12'h000; end
      if (t == 3) g_rep = 1'b0;
      if (t == 6) g_rep = 1'b1;
      if (t == 15) g_rep = 1'b0;
    end

    // Asynchronous reset between clock edges in the middle of a frame
    d_lv = 1'b1; d_data = 12'hEDB; d_rep = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst[%0d]", k), {d_x, d_xv, d_done, d_ready, d_busy},
          pk(seq_a[k], 1'b1, 1'b0, 1'b0, 1'b1));
      if (k == 0) d_lv = 1'b0;
    end
    #2 reset = 1'b0;
    #1 chk("async_rst", {d_x, d_xv, d_done, d_ready, d_busy}, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst[%0d]", k), {d_x, d_xv, d_done, d_ready, d_busy},
          pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    d_lv = 1'b1; d_rep = 1'b0;
    @(negedge clk);
    chk("restart", {d_x, d_xv, d_done, d_ready, d_busy}, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    d_lv = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
